// File: rtl/bp_pkg.sv
// Shared branch-prediction types and constants, used by predictor and resolver.
// Pure declarations: no latency, no backpressure.
package bp_pkg;

   localparam int CNT_W_DEF = 16;

   // 2-bit saturating predictor states
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // One in-flight branch; room left for a PC tag later
   typedef struct packed {
      logic taken;
   } entry_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Prediction issue, resolution and training-strobe handshake of the resolver.
// Wires only: no latency; pred_ready is the only backpressure signal.
interface branch_resolver_if;
   logic pred_valid;
   logic pred_taken;
   logic pred_ready;
   logic res_valid;
   logic res_taken;
   logic upd_valid;
   logic upd_result;
   logic mispredict;

   modport master (
      output pred_valid, pred_taken, res_valid, res_taken,
      input  pred_ready, upd_valid, upd_result, mispredict
   );

   modport slave (
      input  pred_valid, pred_taken, res_valid, res_taken,
      output pred_ready, upd_valid, upd_result, mispredict
   );
endinterface

// File: rtl/branch_fifo.sv
// In-order queue of in-flight branches with single-cycle flush.
// Latency: push visible at head next cycle; no internal backpressure, caller gates push on count.
module branch_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  entry_t                   push_dat,
   input  logic                     pop,
   input  logic                     flush,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   assign head = mem[rd_ptr];

   // Storage needs no reset; only pointers and count define validity
   always_ff @(posedge clk) begin
      if (push && !flush && !reset) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/branch_resolver.sv
// Matches execute outcomes against queued predictions, flushes on mispredict, trains predictor.
// Latency: strobe/stats one cycle after resolution; pred_ready low when full unless a pop frees a slot.
module branch_resolver
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   branch_resolver_if.slave         br,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         total_cnt,
   output logic [CNT_W-1:0]         miss_cnt,
   output logic                     underflow
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   entry_t head;
   entry_t push_dat;
   logic   has_entry;
   logic   pop_ok;
   logic   miss;
   logic   do_push;

   assign has_entry     = (count != '0);
   assign pop_ok        = br.res_valid && has_entry;
   assign miss          = pop_ok && (head.taken != br.res_taken);
   // A resolving pop frees a slot in the same cycle, so a full queue can still accept
   assign br.pred_ready = (count < DEPTH_C) || pop_ok;
   assign do_push       = br.pred_valid && br.pred_ready;
   assign push_dat.taken = br.pred_taken;

   branch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (do_push),
      .push_dat (push_dat),
      .pop      (pop_ok && !miss),
      .flush    (miss),
      .head     (head),
      .count    (count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         br.upd_valid  <= 1'b0;
         br.upd_result <= 1'b0;
         br.mispredict <= 1'b0;
         total_cnt     <= '0;
         miss_cnt      <= '0;
         underflow     <= 1'b0;
      end else begin
         br.upd_valid  <= pop_ok;
         br.upd_result <= pop_ok && br.res_taken;
         br.mispredict <= miss;
         if (pop_ok && (total_cnt != '1)) begin
            total_cnt <= total_cnt + CNT_W'(1);
         end
         if (miss && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + CNT_W'(1);
         end
         if (br.res_valid && !has_entry) begin
            underflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed and random stimulus against a queue-based outcome model; two DUTs (16- and 3-bit stats).
module tb_branch_resolver;
   import bp_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_resolver_if bus ();
   branch_resolver_if bus3 ();

   assign bus3.pred_valid = bus.pred_valid;
   assign bus3.pred_taken = bus.pred_taken;
   assign bus3.res_valid  = bus.res_valid;
   assign bus3.res_taken  = bus.res_taken;

   logic [2:0]  count, count3;
   logic [15:0] total, miss;
   logic [2:0]  total3, miss3;
   logic        uf, uf3;

   branch_resolver #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .br(bus),
      .count(count), .total_cnt(total), .miss_cnt(miss), .underflow(uf)
   );

   branch_resolver #(.DEPTH(DEPTH), .CNT_W(3)) dut3 (
      .clk(clk), .reset(reset), .br(bus3),
      .count(count3), .total_cnt(total3), .miss_cnt(miss3), .underflow(uf3)
   );

   // Reference model state
   bit mq[$];
   int m_total, m_miss, m_total3, m_miss3;
   bit m_uf, e_upd, e_res, e_mis;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("count", 32'(count), mq.size());
      chk("count3", 32'(count3), mq.size());
      chk("upd_valid", 32'(bus.upd_valid), 32'(e_upd));
      chk("upd_valid3", 32'(bus3.upd_valid), 32'(e_upd));
      chk("mispredict", 32'(bus.mispredict), 32'(e_mis));
      if (e_upd) begin
         chk("upd_result", 32'(bus.upd_result), 32'(e_res));
      end
      chk("total_cnt", 32'(total), m_total);
      chk("miss_cnt", 32'(miss), m_miss);
      chk("total_cnt3", 32'(total3), m_total3);
      chk("miss_cnt3", 32'(miss3), m_miss3);
      chk("underflow", 32'(uf), 32'(m_uf));
      chk("underflow3", 32'(uf3), 32'(m_uf));
   endtask

   // One clock of stimulus: ready checked mid-cycle, registered outputs after the edge
   task automatic step(input bit pv, input bit pt, input bit rv, input bit rt);
      int  n;
      bit  ready;
      bit  flushed;
      bit  hd;
      bus.pred_valid = pv;
      bus.pred_taken = pt;
      bus.res_valid  = rv;
      bus.res_taken  = rt;
      @(negedge clk);
      n     = mq.size();
      ready = (n < DEPTH) || (rv && n > 0);
      chk("pred_ready", 32'(bus.pred_ready), 32'(ready));
      chk("pred_ready3", 32'(bus3.pred_ready), 32'(ready));
      flushed = 1'b0;
      e_upd = 1'b0;
      e_mis = 1'b0;
      if (rv && n > 0) begin
         hd       = mq.pop_front();
         e_upd    = 1'b1;
         e_res    = rt;
         m_total  = (m_total  == 65535) ? m_total  : m_total + 1;
         m_total3 = (m_total3 == 7)     ? m_total3 : m_total3 + 1;
         if (hd != rt) begin
            e_mis   = 1'b1;
            flushed = 1'b1;
            mq.delete();
            m_miss  = (m_miss  == 65535) ? m_miss  : m_miss + 1;
            m_miss3 = (m_miss3 == 7)     ? m_miss3 : m_miss3 + 1;
         end
      end else if (rv) begin
         m_uf = 1'b1;
      end
      if (pv && ready && !flushed) begin
         mq.push_back(pt);
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      // Active inputs during reset must be ignored
      bus.pred_valid = 1'b1;
      bus.pred_taken = 1'b1;
      bus.res_valid  = 1'b1;
      bus.res_taken  = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      mq.delete();
      m_total = 0; m_miss = 0; m_total3 = 0; m_miss3 = 0;
      m_uf = 1'b0; e_upd = 1'b0; e_res = 1'b0; e_mis = 1'b0;
      check_outputs();
      chk("upd_result_rst", 32'(bus.upd_result), 0);
      reset = 1'b0;
      bus.pred_valid = 1'b0;
      bus.res_valid  = 1'b0;
   endtask

   function automatic bit head_or_rand();
      if (mq.size() > 0) return mq[0];
      return bit'($urandom_range(0, 1));
   endfunction

   initial begin
      reset = 1'b1;
      bus.pred_valid = 1'b0;
      bus.pred_taken = 1'b0;
      bus.res_valid  = 1'b0;
      bus.res_taken  = 1'b0;
      do_reset();

      // Correct prediction
      step(1, 1, 0, 0);
      step(0, 0, 1, 1);
      chk("correct_total", 32'(total), 1);
      chk("correct_result", 32'(bus.upd_result), 1);

      // Mispredict flush, with a push in the flush cycle
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      chk("three_queued", 32'(count), 3);
      step(1, 1, 1, 0);
      chk("flush_count", 32'(count), 0);
      chk("flush_pulse", 32'(bus.mispredict), 1);
      step(0, 0, 0, 0);

      // Fill, drop a fifth push, then push+pop while full so pointers wrap
      for (int i = 0; i < 4; i++) step(1, bit'(i & 1), 0, 0);
      step(1, 1, 0, 0);
      for (int i = 0; i < 10; i++) step(1, bit'($urandom_range(0, 1)), 1, head_or_rand());
      chk("full_hold", 32'(count), 4);

      // Drain, then underflow which must stay sticky through good traffic
      while (mq.size() > 0) step(0, 0, 1, head_or_rand());
      step(0, 0, 1, 1);
      chk("underflow_set", 32'(uf), 1);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // Saturation of the 3-bit counters
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(1, 1, 0, 0);
         step(0, 0, 1, 0);
      end
      chk("sat_total3", 32'(total3), 7);
      chk("sat_miss3", 32'(miss3), 7);

      // Reset mid-stream, then resolution on the emptied queue
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      do_reset();
      step(0, 0, 1, 1);
      chk("post_reset_uf", 32'(uf), 1);

      // Random traffic, mostly correct resolutions
      for (int i = 0; i < 400; i++) begin
         bit rt;
         rt = ($urandom_range(0, 3) != 0) ? head_or_rand() : bit'($urandom_range(0, 1));
         step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 2) != 0), rt);
         if (i == 200) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
